// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Turns the SPI-written control registers into 16 registered user outputs.
// Each channel is forced low, held high, or follows one shared PWM waveform.
// The PWM period is 256 ticks of a prescaled counter. One duty value applies
// to every PWM channel.
//
// Build option: define PWM_SHADOW_EN to make duty changes take effect only at
// period boundaries. Without it, a duty change applies on the next clk.
//
// Parameters:
//   PRESCALE         clk cycles per PWM count tick (>=1)
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, bits 7:0
//   en_reg_out_15_8  output enable, bits 15:8
//   en_reg_pwm_7_0   PWM-mode select, bits 7:0
//   en_reg_pwm_15_8  PWM-mode select, bits 15:8
//   pwm_duty_cycle   duty; high time = duty/256 of period, 0xFF = always high
//   out              registered channel outputs
//   period_start     one-clk pulse at the start of each PWM period
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned N_CH  = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  prescaler;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_active;
    logic             tick_c;
    logic             wrap_c;
    logic             pwm_level_c;
    logic [N_CH-1:0]  en_out_c;
    logic [N_CH-1:0]  en_pwm_c;
    logic [N_CH-1:0]  out_nxt_c;

    assign en_out_c = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm_c = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // One count tick every PRESCALE clocks; PRESCALE=1 ticks every cycle.
    assign tick_c = (prescaler == PS_W'(PRESCALE - 1));
    assign wrap_c = tick_c && (pwm_cnt == {CNT_W{1'b1}});

    // Prescaler: 0..PRESCALE-1, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick_c) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PS_W'(1);
        end
    end

    // PWM counter: free-running modulo 256 on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick_c) begin
            pwm_cnt <= pwm_cnt + CNT_W'(1);
        end
    end

    // Period marker: the cycle after the 255 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap_c;
        end
    end

`ifdef PWM_SHADOW_EN
    // Shadowed duty: captured only in the wrap cycle, so each period is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (wrap_c) begin
            duty_active <= pwm_duty_cycle;
        end
    end
`else
    // Unshadowed duty: follows the register directly, mid-period glitches allowed.
    assign duty_active = pwm_duty_cycle;
`endif

    // 0xFF is special-cased so full duty never drops low at count 255.
    assign pwm_level_c = (duty_active == {CNT_W{1'b1}}) ? 1'b1 : (pwm_cnt < duty_active);

    // Output enable dominates; PWM select chooses waveform over static high.
    assign out_nxt_c = en_out_c & (~en_pwm_c | {N_CH{pwm_level_c}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_nxt_c;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral: static enable vectors, PWM timing, duty extremes,
// duty change mid-period, random stimulus against a cycle-count model, mid-op reset.
module tb_pwm_peripheral;

    localparam int unsigned P      = 13;
    localparam int unsigned PERIOD = 256 * P;

    logic        clk;
    logic        rst_n;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        ps;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_peripheral #(.PRESCALE(P)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (ps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: everything derives from the clk count since reset release.
    // Counter value = (cycles / PRESCALE) mod 256; the wrap is the last cycle of each
    // 256*PRESCALE block.
    logic [15:0] exp_out = '0;
    logic        exp_ps  = 1'b0;
    int unsigned cyc     = 0;
    logic [7:0]  duty_sh = '0;
    logic [7:0]  duty_eff;
    bit          sb_en   = 1'b0;

`ifdef PWM_SHADOW_EN
    assign duty_eff = duty_sh;
`else
    assign duty_eff = duty;
`endif

    function automatic logic [15:0] model_out(input int unsigned c, input logic [15:0] eo,
                                              input logic [15:0] ep, input logic [7:0] d);
        int unsigned cnt;
        logic        lvl;
        logic [15:0] r;
        cnt = (c / P) % 256;
        lvl = (d == 8'hFF) || (cnt < 32'(d));
        for (int i = 0; i < 16; i++) begin
            if (!eo[i])     r[i] = 1'b0;
            else if (ep[i]) r[i] = lvl;
            else            r[i] = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc     <= 0;
            exp_out <= '0;
            exp_ps  <= 1'b0;
            duty_sh <= '0;
        end else begin
            exp_out <= model_out(cyc, en_out, en_pwm, duty_eff);
            exp_ps  <= ((cyc % PERIOD) == PERIOD - 1);
            if ((cyc % PERIOD) == PERIOD - 1) duty_sh <= duty;
            cyc     <= cyc + 1;
        end
    end

    // Scoreboard: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (sb_en) begin
            check("sb_out", 32'(out), 32'(exp_out));
            check("sb_period_start", 32'(ps), 32'(exp_ps));
        end
    end

    // Waits (bounded) until period_start is seen at a negedge.
    task automatic wait_ps(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < int'(PERIOD) + 20; i++) begin
            @(negedge clk);
            if (ps) begin
                found = 1'b1;
                break;
            end
        end
        check(name, 32'(found), 32'd1);
    endtask

    // Samples n whole periods right after a period_start sighting.
    task automatic measure(input int n, output int hi, output int ps_n, output int ps_bad,
                           output logic [15:0] upper);
        hi = 0; ps_n = 0; ps_bad = 0; upper = '0;
        for (int k = 1; k <= n * int'(PERIOD); k++) begin
            @(negedge clk);
            if (out[0]) hi++;
            upper |= out & 16'hFFFE;
            if (ps) begin
                ps_n++;
                if ((k % int'(PERIOD)) != 0) ps_bad++;
            end
        end
    endtask

    typedef struct {
        logic [15:0] eo;
        logic [15:0] ep;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        int          hi, ps_n, ps_bad, hi1, k_found;
        logic [15:0] upper;

        vecs[0] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[1] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000};
        vecs[3] = '{16'hA5A5, 16'h5A5A, 16'hA5A5};
        vecs[4] = '{16'h00FF, 16'hFF00, 16'h00FF};
        vecs[5] = '{16'h8000, 16'h7FFF, 16'h8000};
        vecs[6] = '{16'h0001, 16'h0000, 16'h0001};
        vecs[7] = '{16'h0000, 16'h0000, 16'h0000};

        // Reset with all inputs high.
        rst_n  = 1'b0;
        en_out = 16'hFFFF;
        en_pwm = 16'hFFFF;
        duty   = 8'hFF;
        repeat (4) @(negedge clk);
        check("reset_out", 32'(out), 32'h0);
        check("reset_period_start", 32'(ps), 32'h0);
        sb_en  = 1'b1;
        rst_n  = 1'b1;
        en_out = '0;
        en_pwm = '0;
        duty   = '0;

        // Static vectors: one clk latency from enable change to output.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en_out = vecs[i].eo;
            en_pwm = vecs[i].ep;
            check($sformatf("vec%0d_hold", i), 32'(out), (i == 0) ? 32'h0 : 32'(vecs[i-1].exp));
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(out), 32'(vecs[i].exp));
        end

        // PWM at duty 0x80 on channel 0.
        en_out = 16'h0001;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        wait_ps("wait_ps_d80");
        measure(1, hi, ps_n, ps_bad, upper);
        check("d80_high_clks", 32'(hi), 32'd1664);
        check("d80_ps_count", 32'(ps_n), 32'd1);
        check("d80_ps_position", 32'(ps_bad), 32'd0);
        check("d80_upper_low", 32'(upper), 32'h0);

        // Duty 0x00 never high.
        duty = 8'h00;
        wait_ps("wait_ps_d00");
        measure(1, hi, ps_n, ps_bad, upper);
        check("d00_high_clks", 32'(hi), 32'd0);

        // Duty 0xFF high across three wraps.
        duty = 8'hFF;
        wait_ps("wait_ps_dff");
        measure(3, hi, ps_n, ps_bad, upper);
        check("dff_high_clks", 32'(hi), 32'(3 * PERIOD));
        check("dff_ps_count", 32'(ps_n), 32'd3);
        check("dff_ps_position", 32'(ps_bad), 32'd0);

        // Duty 0x40 -> 0xC0 part way through a period (cycle 1000 of 3328).
        duty = 8'h40;
        wait_ps("wait_ps_shadow");
        hi1 = 0;
        for (int k = 1; k <= int'(PERIOD); k++) begin
            @(negedge clk);
            if (out[0]) hi1++;
            if (k == 1000) duty = 8'hC0;
        end
`ifdef PWM_SHADOW_EN
        check("shadow_cur_period", 32'(hi1), 32'd832);
`else
        check("shadow_cur_period", 32'(hi1), 32'd2328);
`endif
        measure(1, hi, ps_n, ps_bad, upper);
        check("shadow_next_period", 32'(hi), 32'd2496);

        // Random stimulus against the model.
        for (int r = 0; r < 400; r++) begin
            @(negedge clk);
            en_out = 16'($urandom);
            en_pwm = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       duty = 8'h00;
                1:       duty = 8'hFF;
                default: duty = 8'($urandom);
            endcase
            repeat ($urandom_range(1, 12)) @(negedge clk);
        end

        // Asynchronous reset mid-period, then exact first period_start.
        en_out = 16'hFFFF;
        en_pwm = 16'h0001;
        duty   = 8'h80;
        wait_ps("wait_ps_rst");
        repeat (100 * P) @(negedge clk);
        check("pre_reset_out", 32'(out), 32'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(out), 32'h0);
        check("async_reset_ps", 32'(ps), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k_found = 0;
        for (int k = 1; k <= int'(PERIOD) + 20; k++) begin
            @(negedge clk);
            if (ps) begin
                k_found = k;
                break;
            end
        end
        check("first_ps_after_reset", 32'(k_found), 32'(PERIOD));

        sb_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
